// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared widths and FSM state encoding for the memZ readback.
//  Revision    : 1.0
// ============================================================================
package conv_pkg;

    localparam int DATAWIDTH_Z     = 16;
    localparam int MEM_ADDR_Z_SIZE = 6;
    localparam int SIZE_X          = 5;
    localparam int SIZE_Y          = 5;
    localparam int LEN_W           = SIZE_X + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_z_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_z_reader_if
//  Description : memZ read port plus the valid/ready result stream.
//  Revision    : 1.0
// ============================================================================
interface conv_z_reader_if #(
    parameter int DATAWIDTH_Z     = conv_pkg::DATAWIDTH_Z,
    parameter int MEM_ADDR_Z_SIZE = conv_pkg::MEM_ADDR_Z_SIZE
);
    logic [MEM_ADDR_Z_SIZE-1:0] memZ_addr;
    logic                       memZ_rd;
    logic [DATAWIDTH_Z-1:0]     dataZ;
    logic [DATAWIDTH_Z-1:0]     out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output memZ_addr, memZ_rd, out_data, out_valid, out_last,
        input  dataZ, out_ready
    );

    modport slave (
        input  memZ_addr, memZ_rd, out_data, out_valid, out_last,
        output dataZ, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/conv_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : conv_skid_fifo
//  Description : Two-entry synchronous FIFO; push and pop may coincide when full.
//  Revision    : 1.0
// ============================================================================
module conv_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] dataIn,
    output logic      [WIDTH-1:0] dataOut,
    output logic                  full,
    output logic                  empty,
    output logic      [1:0]       count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [1:0]       r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPop  = pop && (r_count != 2'd0);
    assign w_doPush = push && ((r_count != 2'd2) || w_doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= dataIn;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dataOut = r_mem[r_rdPtr];
    assign full    = (r_count == 2'd2);
    assign empty   = (r_count == 2'd0);
    assign count   = r_count;
endmodule
`default_nettype wire

// File: rtl/conv_z_reader.sv
`default_nettype none
// ============================================================================
//  Module      : conv_z_reader
//  Description : Streams memZ results 0..len-1 out over valid/ready with last.
//  Revision    : 1.0
// ============================================================================
module conv_z_reader #(
    parameter int DATAWIDTH_Z     = conv_pkg::DATAWIDTH_Z,
    parameter int MEM_ADDR_Z_SIZE = conv_pkg::MEM_ADDR_Z_SIZE,
    parameter int SIZE_X          = conv_pkg::SIZE_X,
    parameter int SIZE_Y          = conv_pkg::SIZE_Y
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [SIZE_X-1:0] sizeX,
    input  wire logic [SIZE_Y-1:0] sizeY,
    input  wire logic              shape,
    output logic                   busy,
    output logic                   done,
    conv_z_reader_if.master        bus
);
    import conv_pkg::*;

    localparam int c_lenW = SIZE_X + 1;

    state_t                     r_state;
    state_t                     w_stateNext;
    logic [c_lenW-1:0]          r_len;
    logic [c_lenW-1:0]          r_beatCnt;
    logic [c_lenW-1:0]          w_lenCalc;
    logic [MEM_ADDR_Z_SIZE-1:0] r_rdAddr;
    logic                       r_inFlight;
    logic                       w_rd;
    logic                       w_flush;
    logic                       w_pop;
    logic                       w_valid;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_credit;
    logic                       w_lastRead;
    logic                       w_lastBeat;
    logic [1:0]                 w_count;
    logic [2:0]                 w_occ;
    logic [DATAWIDTH_Z-1:0]     w_head;

    conv_skid_fifo #(.WIDTH(DATAWIDTH_Z)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (w_flush),
        .push    (r_inFlight),
        .pop     (w_pop),
        .dataIn  (bus.dataZ),
        .dataOut (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_comb begin
        w_lenCalc = '0;
        if ((sizeX != '0) && (sizeY != '0)) begin
            if (shape) w_lenCalc = c_lenW'(sizeX);
            else       w_lenCalc = c_lenW'(sizeX) + c_lenW'(sizeY) - c_lenW'(1);
        end
    end

    assign w_valid    = !w_empty;
    assign w_pop      = w_valid && bus.out_ready;
    assign w_lastBeat = w_valid && (r_beatCnt == r_len - c_lenW'(1));
    assign w_lastRead = (c_lenW'(r_rdAddr) == r_len - c_lenW'(1));

    // Credit covers the buffered beats plus the one read whose data lands next cycle.
    assign w_occ    = {1'b0, w_count} + {2'b00, r_inFlight};
    assign w_credit = w_full ? (w_pop && !r_inFlight)
                             : (w_occ < (3'd2 + {2'b00, w_pop}));

    always_comb begin
        w_stateNext = r_state;
        w_rd        = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_flush     = 1'b1;
                    w_stateNext = (w_lenCalc != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (w_credit) begin
                    w_rd = 1'b1;
                    if (w_lastRead) w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_lastBeat) w_stateNext = DONE;
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_rdAddr   <= '0;
            r_beatCnt  <= '0;
            r_inFlight <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_inFlight <= w_rd;
            if ((r_state == IDLE) && start) begin
                r_len     <= w_lenCalc;
                r_rdAddr  <= '0;
                r_beatCnt <= '0;
            end else begin
                // Address parks on len-1 after the final read rather than running past it.
                if (w_rd && !w_lastRead) r_rdAddr <= r_rdAddr + MEM_ADDR_Z_SIZE'(1);
                if (w_pop) r_beatCnt <= r_beatCnt + c_lenW'(1);
            end
        end
    end

    assign bus.memZ_rd   = w_rd;
    assign bus.memZ_addr = r_rdAddr;
    assign bus.out_data  = w_head;
    assign bus.out_valid = w_valid;
    assign bus.out_last  = w_lastBeat;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
endmodule
`default_nettype wire
